axi_rr_arbiter: RTL and testbench
=================================

AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all channels.
REQ-002 Parameter DATA_W, 32, data width; strobe width is DATA_W/8.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 m0_araddr/m0_arvalid  in  ADDR_W/1; m0_arready  out  1 -- master 0 (IFU) read address.
REQ-007 m0_rdata/m0_rresp/m0_rvalid  out  DATA_W/2/1; m0_rready  in  1 -- master 0 read data.
REQ-008 m1_araddr/m1_arvalid  in  ADDR_W/1; m1_arready  out  1 -- master 1 (LSU) read address.
REQ-009 m1_rdata/m1_rresp/m1_rvalid  out  DATA_W/2/1; m1_rready  in  1 -- master 1 read data.
REQ-010 m1_awaddr/m1_awvalid  in  ADDR_W/1; m1_awready  out  1 -- master 1 write address.
REQ-011 m1_wdata/m1_wstrb/m1_wvalid  in  DATA_W/DATA_W/8/1; m1_wready  out  1 -- master 1 write data.
REQ-012 m1_bresp/m1_bvalid  out  2/1; m1_bready  in  1 -- master 1 write response.
REQ-013 s_araddr/s_arvalid  out  ADDR_W/1; s_arready  in  1 -- slave read address.
REQ-014 s_rdata/s_rresp/s_rvalid  in  DATA_W/2/1; s_rready  out  1 -- slave read data.
REQ-015 s_awaddr/s_awvalid, s_wdata/s_wstrb/s_wvalid  out; s_awready/s_wready  in -- slave write address/data.
REQ-016 s_bresp/s_bvalid  in  2/1; s_bready  out  1 -- slave write response.

Function
REQ-017 States SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; exactly one transaction outstanding at the slave.
REQ-018 Candidates in IDLE: C0 = m0_arvalid; C1 = m1_awvalid && m1_wvalid (write) else m1_arvalid (read); m1 write beats m1 read.
REQ-019 Round-robin: 1-bit last_grant; if both C0 and C1 pending, grant the master not equal to last_grant; single pending candidate wins.
REQ-020 Accept cycle (IDLE, winner present): pulse winner's arready (read) or awready and wready together (write) for exactly one cycle; latch address/data/strobe and owner; no ready to the loser.
REQ-021 IDLE with no candidate: all ready outputs 0; state holds.
REQ-022 RD_ADDR: s_arvalid=1, s_araddr=latched address; on s_arready -> RD_DATA.
REQ-023 RD_DATA: owner rvalid/rdata/rresp = slave values, s_rready = owner rready, non-owner rvalid=0; on s_rvalid && s_rready -> IDLE, last_grant <= owner.
REQ-024 WR_REQ: s_awvalid and s_wvalid driven from latched values independently; aw_done/w_done flags set on respective handshakes (same cycle allowed); each valid drops once its flag is set; both done -> WR_RESP.
REQ-025 WR_RESP: m1_bvalid/m1_bresp = s_bvalid/s_bresp, s_bready = m1_bready; on handshake -> IDLE, last_grant <= 1.
REQ-026 Responses (rresp/bresp incl. SLVERR/DECERR) SHALL pass through unmodified; no timeout.
REQ-027 Latency: accept cycle + 1 cycle min to s_arvalid/s_awvalid; back-to-back transactions SHALL have one IDLE cycle between them.
REQ-028 Upstream request changes after acceptance SHALL NOT affect the in-flight slave transaction (latched copy used).
REQ-029 All outputs not listed active in a state SHALL be 0; data outputs 0 when corresponding valid is 0.

Reset
REQ-030 On rst low: state=IDLE, last_grant=1 (m0 wins first tie), aw_done=w_done=0, all valid/ready outputs 0, latched regs 0 -- immediately, independent of clk.
REQ-031 Reset mid-transaction SHALL abandon it; no response is delivered after reset release.

Verification
REQ-032 Tie: m0 read 0x8000_0000 and m1 read 0x8000_0100 same cycle after reset -> m0 granted first, m1 serviced next; s_araddr sequence 0x8000_0000, 0x8000_0100.
REQ-033 Alternation: m0 and m1 both continuously requesting for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-034 Write: m1 aw=0x8000_0010, w=0xDEADBEEF, strb=0xF; slave s_wready 2 cycles after s_awready -> s_awvalid drops after its handshake, s_wvalid held until its handshake, m1_bvalid with bresp=0 once.
REQ-035 Priority: m1 write and m1 read both valid, m0 idle -> write accepted first, m1_arready stays 0 that cycle.
REQ-036 Backpressure: s_rvalid with m0_rready=0 for 3 cycles -> m0_rvalid held, state stays RD_DATA, rdata stable until m0_rready=1.
REQ-037 Reset asserted in RD_DATA -> all valids 0 same cycle; after release a fresh m0 read completes normally.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// Two-master to one-slave AXI-lite style arbiter: m0 (IFU, read-only) and m1 (LSU, read/write)
// share a single slave with round-robin arbitration and one transaction outstanding at a time.
module axi_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 read channels
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // master 1 read channels
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  // master 1 write channels
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // slave channels
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              state_reg;
  logic                last_grant_reg;
  logic                owner_reg;
  logic                aw_done_reg;
  logic                w_done_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;

  logic c0, c1, c1_wr, grant1, accept;
  logic in_idle, in_rd_addr, in_rd_data, in_wr_req, in_wr_resp;
  logic m0_sel, m1_sel;
  logic aw_done_next, w_done_next;

  assign in_idle    = (state_reg == IDLE);
  assign in_rd_addr = (state_reg == RD_ADDR);
  assign in_rd_data = (state_reg == RD_DATA);
  assign in_wr_req  = (state_reg == WR_REQ);
  assign in_wr_resp = (state_reg == WR_RESP);

  // An m1 write needs both address and data present; it beats an m1 read.
  assign c0     = m0_arvalid;
  assign c1_wr  = m1_awvalid & m1_wvalid;
  assign c1     = c1_wr | m1_arvalid;
  assign grant1 = c1 & (~c0 | ~last_grant_reg);
  // The rst term keeps the readies low while reset is held even though state is already IDLE.
  assign accept = rst & in_idle & (c0 | c1);

  assign m0_arready = accept & ~grant1;
  assign m1_arready = accept & grant1 & ~c1_wr;
  assign m1_awready = accept & grant1 & c1_wr;
  assign m1_wready  = accept & grant1 & c1_wr;

  assign s_arvalid = in_rd_addr;
  assign s_araddr  = in_rd_addr ? addr_reg : '0;

  assign m0_sel    = in_rd_data & ~owner_reg;
  assign m1_sel    = in_rd_data & owner_reg;
  assign m0_rvalid = m0_sel & s_rvalid;
  assign m0_rdata  = m0_rvalid ? s_rdata : '0;
  assign m0_rresp  = m0_rvalid ? s_rresp : 2'b00;
  assign m1_rvalid = m1_sel & s_rvalid;
  assign m1_rdata  = m1_rvalid ? s_rdata : '0;
  assign m1_rresp  = m1_rvalid ? s_rresp : 2'b00;
  assign s_rready  = (m0_sel & m0_rready) | (m1_sel & m1_rready);

  assign s_awvalid = in_wr_req & ~aw_done_reg;
  assign s_awaddr  = s_awvalid ? addr_reg : '0;
  assign s_wvalid  = in_wr_req & ~w_done_reg;
  assign s_wdata   = s_wvalid ? wdata_reg : '0;
  assign s_wstrb   = s_wvalid ? wstrb_reg : '0;

  assign m1_bvalid = in_wr_resp & s_bvalid;
  assign m1_bresp  = m1_bvalid ? s_bresp : 2'b00;
  assign s_bready  = in_wr_resp & m1_bready;

  assign aw_done_next = aw_done_reg | (s_awvalid & s_awready);
  assign w_done_next  = w_done_reg | (s_wvalid & s_wready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg <= grant1;
            if (grant1 && c1_wr) begin
              addr_reg  <= m1_awaddr;
              wdata_reg <= m1_wdata;
              wstrb_reg <= m1_wstrb;
              state_reg <= WR_REQ;
            end else begin
              addr_reg  <= grant1 ? m1_araddr : m0_araddr;
              state_reg <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (s_arready) state_reg <= RD_DATA;
        end
        RD_DATA: begin
          if (s_rvalid && s_rready) begin
            state_reg      <= IDLE;
            last_grant_reg <= owner_reg;
          end
        end
        WR_REQ: begin
          // Address and data handshakes complete independently; clear both flags on exit.
          if (aw_done_next && w_done_next) begin
            state_reg   <= WR_RESP;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
          end else begin
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
          end
        end
        WR_RESP: begin
          if (s_bvalid && m1_bready) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Scoreboard bench for axi_rr_arbiter: directed master requests, a slave model fed from
// response queues, and monitors that pop expected grants/requests/responses on each handshake.
module tb_axi_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rvalid, m0_rready;
  logic [31:0] m1_araddr;
  logic        m1_arvalid, m1_arready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr;
  logic        m1_awvalid, m1_awready;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_wvalid, m1_wready;
  logic [1:0]  m1_bresp;
  logic        m1_bvalid, m1_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;

  axi_rr_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sreq_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  logic [3:0]  grant_q[$];
  sreq_t       sreq_q[$];
  rsp_t        srsp_q[$];
  rsp_t        m0_q[$];
  rsp_t        m1r_q[$];
  logic [1:0]  b_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  wire [11:0] ctl_all = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                         m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic exp_rd(input bit m, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] r, input bit deliver);
    rsp_t rs;
    rs = '{d, r};
    grant_q.push_back(m ? 4'b0010 : 4'b0001);
    sreq_q.push_back('{1'b0, a, 32'h0, 4'h0});
    srsp_q.push_back(rs);
    if (deliver) begin
      if (m) m1r_q.push_back(rs);
      else   m0_q.push_back(rs);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] r);
    grant_q.push_back(4'b1100);
    sreq_q.push_back('{1'b1, a, d, s});
    srsp_q.push_back('{32'h0, r});
    b_q.push_back(r);
  endtask

  // Master drivers: inputs change 1 time unit after a rising edge; readiness sampled on falling edge.
  task automatic m0_read(input logic [31:0] a);
    bit ok = 0;
    @(posedge clk); #1;
    m0_arvalid = 1'b1; m0_araddr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m0_arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    m0_arvalid = 1'b0; m0_araddr = '0;
    if (!ok) check("m0_ar_timeout", 0, 1);
  endtask

  task automatic m1_read(input logic [31:0] a);
    bit ok = 0;
    @(posedge clk); #1;
    m1_arvalid = 1'b1; m1_araddr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m1_arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    m1_arvalid = 1'b0; m1_araddr = '0;
    if (!ok) check("m1_ar_timeout", 0, 1);
  endtask

  task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    @(posedge clk); #1;
    m1_awvalid = 1'b1; m1_awaddr = a; m1_wvalid = 1'b1; m1_wdata = d; m1_wstrb = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m1_awready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    m1_awvalid = 1'b0; m1_awaddr = '0; m1_wvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0;
    if (!ok) check("m1_aw_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant_q.size() == 0 && sreq_q.size() == 0 && srsp_q.size() == 0 &&
          m0_q.size() == 0 && m1r_q.size() == 0 && b_q.size() == 0) begin
        ok = 1; break;
      end
    end
    if (!ok) begin
      check("drain_pending", {grant_q.size(), sreq_q.size(), m0_q.size(), m1r_q.size()}, 0);
      grant_q.delete(); sreq_q.delete(); srsp_q.delete();
      m0_q.delete(); m1r_q.delete(); b_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Slave model: always ready for addresses, data response one cycle after the address phase,
  // write data accepted two cycles after the address handshake.
  initial begin : slave_bfm
    sreq_t rq;
    rsp_t  rs;
    bit    ok;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b0;
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_bvalid = 1'b0; s_bresp = '0;
    forever begin
      @(negedge clk);
      if (rst && (s_arvalid || s_awvalid)) begin
        rq = '{1'b0, 32'h0, 32'h0, 4'h0};
        rs = '{32'h0, 2'b00};
        if (sreq_q.size() == 0) check("s_req_unexpected", {s_arvalid, s_awvalid}, 0);
        else rq = sreq_q.pop_front();
        if (srsp_q.size() != 0) rs = srsp_q.pop_front();
        if (s_arvalid) begin
          check("s_araddr", {rq.wr, s_araddr}, {1'b0, rq.addr});
          $display("slave AR addr=%h", s_araddr);
          @(posedge clk); #1;
          s_rvalid = 1'b1; s_rdata = rs.data; s_rresp = rs.resp;
          ok = 0;
          for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!rst) break;
            if (s_rready) begin ok = 1; break; end
          end
          if (ok) begin @(posedge clk); #1; end
          else if (rst) check("s_r_timeout", 0, 1);
          s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        end else begin
          check("s_awaddr", {rq.wr, s_awaddr}, {1'b1, rq.addr});
          $display("slave AW addr=%h", s_awaddr);
          @(posedge clk);
          repeat (2) begin
            @(negedge clk);
            check("s_awvalid_dropped", s_awvalid, 0);
            check("s_wvalid_held", s_wvalid, 1);
            @(posedge clk);
          end
          #1 s_wready = 1'b1;
          @(negedge clk);
          check("s_wvalid_at_hs", s_wvalid, 1);
          check("s_wstrb_wdata", {s_wstrb, s_wdata}, {rq.strb, rq.data});
          $display("slave W data=%h strb=%h", s_wdata, s_wstrb);
          @(posedge clk); #1;
          s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = rs.resp;
          ok = 0;
          for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!rst) break;
            if (s_bready) begin ok = 1; break; end
          end
          if (ok) begin @(posedge clk); #1; end
          else if (rst) check("s_b_timeout", 0, 1);
          s_bvalid = 1'b0; s_bresp = '0;
        end
      end
    end
  end

  // Grant monitor: the pattern of readies in an accept cycle must match the expected winner.
  always @(negedge clk) begin
    logic [3:0] gv;
    gv = {m1_wready, m1_awready, m1_arready, m0_arready};
    if (rst && gv != 4'b0000) begin
      if (grant_q.size() == 0) check("grant_unexpected", gv, 0);
      else begin
        check("grant", gv, grant_q.pop_front());
        $display("grant readies=%b", gv);
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (rst && m0_rvalid && m0_rready) begin
      if (m0_q.size() == 0) check("m0_r_unexpected", m0_rdata, 0);
      else begin
        e = m0_q.pop_front();
        check("m0_r", {m0_rresp, m0_rdata}, {e.resp, e.data});
        $display("m0 R data=%h resp=%0d", m0_rdata, m0_rresp);
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (rst && m1_rvalid && m1_rready) begin
      if (m1r_q.size() == 0) check("m1_r_unexpected", m1_rdata, 0);
      else begin
        e = m1r_q.pop_front();
        check("m1_r", {m1_rresp, m1_rdata}, {e.resp, e.data});
        $display("m1 R data=%h resp=%0d", m1_rdata, m1_rresp);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && m1_bvalid && m1_bready) begin
      if (b_q.size() == 0) check("m1_b_unexpected", {1'b1, m1_bresp}, 0);
      else begin
        check("m1_bresp", m1_bresp, b_q.pop_front());
        $display("m1 B resp=%0d", m1_bresp);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0;
    m0_araddr = '0; m1_araddr = '0; m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0;
    m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
    // Requests present during reset must not be granted.
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl_all_zero", ctl_all, 0);
    check("reset_s_araddr", s_araddr, 0);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Tie straight after reset: m0 first, then m1.
    exp_rd(0, 32'h8000_0000, 32'h1111_0000, 2'b00, 1);
    exp_rd(1, 32'h8000_0100, 32'h2222_0000, 2'b00, 1);
    fork
      m0_read(32'h8000_0000);
      m1_read(32'h8000_0100);
    join
    drain();

    // Both masters continuously requesting: strict alternation, error responses pass through.
    exp_rd(0, 32'h8000_1000, 32'hA000_0001, 2'b00, 1);
    exp_rd(1, 32'h8000_2000, 32'hB000_0001, 2'b10, 1);
    exp_rd(0, 32'h8000_1004, 32'hA000_0002, 2'b11, 1);
    exp_rd(1, 32'h8000_2004, 32'hB000_0002, 2'b00, 1);
    exp_rd(0, 32'h8000_1008, 32'hA000_0003, 2'b00, 1);
    exp_rd(1, 32'h8000_2008, 32'hB000_0003, 2'b01, 1);
    fork
      begin
        m0_read(32'h8000_1000); m0_read(32'h8000_1004); m0_read(32'h8000_1008);
      end
      begin
        m1_read(32'h8000_2000); m1_read(32'h8000_2004); m1_read(32'h8000_2008);
      end
    join
    drain();

    // Single write with delayed slave wready.
    exp_wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
    m1_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    drain();

    // m1 write and read together: write first, SLVERR passed through.
    exp_wr(32'h8000_0020, 32'h0BAD_F00D, 4'h3, 2'b10);
    exp_rd(1, 32'h8000_0030, 32'h3333_4444, 2'b00, 1);
    fork
      m1_write(32'h8000_0020, 32'h0BAD_F00D, 4'h3);
      m1_read(32'h8000_0030);
    join
    drain();

    // Backpressure: m0 holds rready low for three cycles of a valid response.
    m0_rready = 1'b0;
    exp_rd(0, 32'h8000_0200, 32'hCAFE_F00D, 2'b00, 1);
    m0_read(32'h8000_0200);
    begin : wait_rvalid
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (m0_rvalid) begin seen = 1; break; end
      end
      check("bp_rvalid_seen", seen, 1);
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_rvalid_held", m0_rvalid, 1);
      check("bp_rdata_stable", m0_rdata, 32'hCAFE_F00D);
      check("bp_s_rready_low", s_rready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 m0_rready = 1'b1;
    drain();

    // Reset in RD_DATA abandons the read; a fresh read afterwards completes.
    m0_rready = 1'b0;
    exp_rd(0, 32'h8000_0300, 32'h5555_6666, 2'b00, 0);
    m0_read(32'h8000_0300);
    begin : wait_rd_data
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (m0_rvalid) begin seen = 1; break; end
      end
      check("rst_rd_data_reached", seen, 1);
    end
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("rst_mid_ctl_all_zero", ctl_all, 0);
    check("rst_mid_m0_rdata", m0_rdata, 0);
    m0_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", ctl_all, 0);
    exp_rd(0, 32'h8000_0400, 32'h7777_8888, 2'b00, 1);
    m0_read(32'h8000_0400);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
